parking_ctrl: RTL and testbench

PARKING_CTRL -- requirements
Module: parking_ctrl

---
 rtl/parking_pkg.sv | 32 +++
 rtl/parking_ctrl_blink_gen.sv | 52 +++++
 rtl/parking_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_parking_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parking_pkg                                                        |
// | Shared FSM encoding and width helpers for the parking controller.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_EXIT  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

  localparam int c_stat_w = 16;

  // Blink counter runs 0..div-1.
  function automatic int blink_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // One timer serves both DOOR and FULL, so size it for the longer of the two.
  function automatic int timer_w(input int door_ticks, input int full_ticks);
    int m;
    m = (door_ticks > full_ticks) ? door_ticks : full_ticks;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_ctrl_blink_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | blink_gen                                                          |
// | Indicator that is 1 on the first enabled cycle, then toggles every |
// | BLINK_DIV cycles; 0 whenever disabled.                             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module blink_gen
  import parking_pkg::*;
#(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic light
);

  localparam int                 c_cnt_w = blink_cnt_w(BLINK_DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BLINK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_run;
  logic               r_light;

  // enable is the owner's next-state view, so the light is already on
  // during the first cycle of the phase it decorates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_light <= 1'b0;
    end else if (!enable) begin
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_light <= 1'b0;
    end else if (!r_run) begin
      r_cnt   <= '0;
      r_run   <= 1'b1;
      r_light <= 1'b1;
    end else if (r_cnt == c_last) begin
      r_cnt   <= '0;
      r_light <= ~r_light;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign light = r_light;

endmodule
`default_nettype wire

// File: rtl/parking_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parking_ctrl                                                       |
// | Parking bay allocator: entry/exit FSM, occupancy bitmap, door and  |
// | full indicators. Define PARKING_STATS_EN for saturating counters.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module parking_ctrl
  import parking_pkg::*;
#(
  parameter  int SLOTS      = 4,
  parameter  int DOOR_TICKS = 40,
  parameter  int FULL_TICKS = 24,
  parameter  int BLINK_DIV  = 4,
  localparam int SW         = $clog2(SLOTS),
  localparam int CW         = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [SW-1:0]    exit_slot,
  output logic             entry_ack,
  output logic [SW-1:0]    grant_slot,
  output logic             exit_ack,
  output logic             exit_err,
  output logic [SLOTS-1:0] occupied,
  output logic [CW-1:0]    free_count,
  output logic [SW-1:0]    next_slot,
  output logic             door_light,
  output logic             full_light,
  output logic [2:0]       state
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0]      total_entries,
  output logic [15:0]      total_exits,
  output logic [15:0]      total_rejects
`endif
);

  localparam int              c_tmr_w     = timer_w(DOOR_TICKS, FULL_TICKS);
  localparam logic [SW:0]     c_slots_ext = (SW + 1)'(SLOTS);
  localparam int              c_pad_w     = 2 ** SW;

  state_t               r_state;
  state_t               w_next_state;
  logic [SLOTS-1:0]     r_occupied;
  logic [CW-1:0]        r_free_count;
  logic [SW-1:0]        r_grant_slot;
  logic [SW-1:0]        w_next_slot;
  logic                 r_entry_ack;
  logic                 r_exit_ack;
  logic                 r_exit_err;
  logic [c_tmr_w-1:0]   r_timer;
  logic [c_pad_w-1:0]   w_occ_pad;
  logic                 w_have_free;
  logic                 w_exit_ok;
  logic                 w_timer_done;
  logic                 w_entry_grant;
  logic                 w_entry_reject;
  logic                 w_exit_grant;
  logic                 w_exit_reject;

  // Padding lets exit_slot index safely when SLOTS is not a power of two.
  assign w_occ_pad    = c_pad_w'(r_occupied);
  assign w_have_free  = (r_free_count != '0);
  assign w_exit_ok    = ({1'b0, exit_slot} < c_slots_ext) && w_occ_pad[exit_slot];
  assign w_timer_done = (r_state == ST_DOOR) ? (r_timer == c_tmr_w'(DOOR_TICKS - 1))
                                             : (r_timer == c_tmr_w'(FULL_TICKS - 1));

  always_comb begin
    w_next_slot = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_occupied[i]) w_next_slot = SW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_entry_grant  = 1'b0;
    w_entry_reject = 1'b0;
    w_exit_grant   = 1'b0;
    w_exit_reject  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (entry_req)     w_next_state = ST_ENTRY;
        else if (exit_req) w_next_state = ST_EXIT;
      end
      ST_ENTRY: begin
        w_entry_grant  = w_have_free;
        w_entry_reject = !w_have_free;
        w_next_state   = w_have_free ? ST_DOOR : ST_FULL;
      end
      ST_EXIT: begin
        w_exit_grant  = w_exit_ok;
        w_exit_reject = !w_exit_ok;
        w_next_state  = w_exit_ok ? ST_DOOR : ST_IDLE;
      end
      ST_DOOR, ST_FULL: begin
        if (w_timer_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occupied   <= '0;
      r_free_count <= CW'(SLOTS);
      r_grant_slot <= '0;
      r_entry_ack  <= 1'b0;
      r_exit_ack   <= 1'b0;
      r_exit_err   <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_entry_ack <= w_entry_grant;
      r_exit_ack  <= w_exit_grant;
      r_exit_err  <= w_exit_reject;
      if (w_entry_grant) begin
        r_occupied   <= r_occupied | (SLOTS'(1) << w_next_slot);
        r_free_count <= r_free_count - 1'b1;
        r_grant_slot <= w_next_slot;
      end else if (w_exit_grant) begin
        r_occupied   <= r_occupied & ~(SLOTS'(1) << exit_slot);
        r_free_count <= r_free_count + 1'b1;
      end
      if ((r_state == ST_DOOR || r_state == ST_FULL) && !w_timer_done)
        r_timer <= r_timer + 1'b1;
      else
        r_timer <= '0;
    end
  end

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_door_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_next_state == ST_DOOR),
    .light   (door_light)
  );

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_full_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_next_state == ST_FULL),
    .light   (full_light)
  );

`ifdef PARKING_STATS_EN
  logic [c_stat_w-1:0] r_total_entries;
  logic [c_stat_w-1:0] r_total_exits;
  logic [c_stat_w-1:0] r_total_rejects;

  // Counters move on the same edge that registers the matching pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total_entries <= '0;
      r_total_exits   <= '0;
      r_total_rejects <= '0;
    end else begin
      if (w_entry_grant && r_total_entries != '1)  r_total_entries <= r_total_entries + 1'b1;
      if (w_exit_grant && r_total_exits != '1)     r_total_exits   <= r_total_exits + 1'b1;
      if (w_entry_reject && r_total_rejects != '1) r_total_rejects <= r_total_rejects + 1'b1;
    end
  end

  assign total_entries = r_total_entries;
  assign total_exits   = r_total_exits;
  assign total_rejects = r_total_rejects;
`endif

  assign entry_ack  = r_entry_ack;
  assign grant_slot = r_grant_slot;
  assign exit_ack   = r_exit_ack;
  assign exit_err   = r_exit_err;
  assign occupied   = r_occupied;
  assign free_count = r_free_count;
  assign next_slot  = w_next_slot;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_parking_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_parking_ctrl                                                    |
// | Self-checking bench for parking_ctrl against a bay-array model.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_parking_ctrl;
  import parking_pkg::*;

  localparam int SLOTS      = 4;
  localparam int DOOR_TICKS = 8;
  localparam int FULL_TICKS = 6;
  localparam int BLINK_DIV  = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       entry_ack;
  logic [1:0] grant_slot;
  logic       exit_ack;
  logic       exit_err;
  logic [3:0] occupied;
  logic [2:0] free_count;
  logic [1:0] next_slot;
  logic       door_light;
  logic       full_light;
  logic [2:0] state;
`ifdef PARKING_STATS_EN
  logic [15:0] total_entries;
  logic [15:0] total_exits;
  logic [15:0] total_rejects;
`endif

  int checks = 0;
  int errors = 0;
  bit m_occ[SLOTS];

  parking_ctrl #(
    .SLOTS(SLOTS), .DOOR_TICKS(DOOR_TICKS), .FULL_TICKS(FULL_TICKS), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .entry_ack(entry_ack), .grant_slot(grant_slot),
    .exit_ack(exit_ack), .exit_err(exit_err), .occupied(occupied),
    .free_count(free_count), .next_slot(next_slot), .door_light(door_light),
    .full_light(full_light), .state(state)
`ifdef PARKING_STATS_EN
    , .total_entries(total_entries), .total_exits(total_exits), .total_rejects(total_rejects)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    for (int i = 0; i < SLOTS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic logic [2:0] model_free();
    int n = SLOTS;
    for (int i = 0; i < SLOTS; i++) if (m_occ[i]) n--;
    return 3'(n);
  endfunction

  function automatic logic [1:0] model_next();
    for (int i = 0; i < SLOTS; i++) if (!m_occ[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0;
    for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One request presented in IDLE, followed through to the return to IDLE.
  task automatic do_op(input bit is_entry, input int slot, input bit both, input string tag);
    int     exp_slot;
    bit     exp_ok;
    int     exp_len;
    int     len;
    state_t exp_st;
    logic   lit, other;
    exp_slot = -1;
    for (int i = 0; i < SLOTS; i++) if (!m_occ[i] && exp_slot < 0) exp_slot = i;
    exp_ok = is_entry ? (exp_slot >= 0) : m_occ[slot];
    entry_req = is_entry; exit_req = !is_entry || both; exit_slot = 2'(slot);
    @(negedge clk);
    entry_req = 1'b0; exit_req = 1'b0;
    checks++;
    if (state !== (is_entry ? ST_ENTRY : ST_EXIT)) begin
      errors++; $display("FAIL %s req_state: got %0d expected %0d", tag, state, is_entry ? ST_ENTRY : ST_EXIT);
    end
    @(negedge clk);
    checks++;
    if (entry_ack !== (is_entry && exp_ok) || exit_ack !== (!is_entry && exp_ok) ||
        exit_err !== (!is_entry && !exp_ok)) begin
      errors++; $display("FAIL %s pulses: got ea=%b xa=%b xe=%b expected ea=%b xa=%b xe=%b", tag,
                         entry_ack, exit_ack, exit_err, is_entry && exp_ok, !is_entry && exp_ok, !is_entry && !exp_ok);
    end
    if (is_entry && exp_ok) begin
      checks++;
      if (grant_slot !== 2'(exp_slot)) begin
        errors++; $display("FAIL %s grant_slot: got %0d expected %0d", tag, grant_slot, exp_slot);
      end
    end
    if (exp_ok) begin
      if (is_entry) m_occ[exp_slot] = 1'b1;
      else          m_occ[slot] = 1'b0;
    end
    checks++;
    if (occupied !== model_vec() || free_count !== model_free() || next_slot !== model_next()) begin
      errors++; $display("FAIL %s bitmap: got occ=%b free=%0d next=%0d expected occ=%b free=%0d next=%0d", tag,
                         occupied, free_count, next_slot, model_vec(), model_free(), model_next());
    end
    if (exp_ok)        begin exp_st = ST_DOOR; exp_len = DOOR_TICKS; end
    else if (is_entry) begin exp_st = ST_FULL; exp_len = FULL_TICKS; end
    else               begin exp_st = ST_IDLE; exp_len = 0; end
    len = 0;
    while (exp_len > 0 && state === exp_st && len < 200) begin
      lit   = (exp_st == ST_DOOR) ? door_light : full_light;
      other = (exp_st == ST_DOOR) ? full_light : door_light;
      checks++;
      if (lit !== (((len / BLINK_DIV) % 2) == 0) || other !== 1'b0) begin
        errors++; $display("FAIL %s light_cycle%0d: got %b/%b expected %b/0", tag, len, lit, other,
                           ((len / BLINK_DIV) % 2) == 0);
      end
      if (len > 0) begin
        checks++;
        if ((entry_ack | exit_ack | exit_err) !== 1'b0) begin
          errors++; $display("FAIL %s pulse_len: pulse still high in cycle %0d", tag, len);
        end
      end
      len++;
      @(negedge clk);
    end
    checks++;
    if (len !== exp_len) begin
      errors++; $display("FAIL %s phase_len: got %0d expected %0d", tag, len, exp_len);
    end
    if (exp_len == 0) begin
      checks++;
      if (state !== ST_IDLE) begin
        errors++; $display("FAIL %s err_state: got %0d expected %0d", tag, state, ST_IDLE);
      end
      @(negedge clk);
    end
    checks++;
    if (state !== ST_IDLE || door_light !== 1'b0 || full_light !== 1'b0 ||
        (entry_ack | exit_ack | exit_err) !== 1'b0) begin
      errors++; $display("FAIL %s back_idle: got st=%0d dl=%b fl=%b pulses=%b expected idle, all 0", tag,
                         state, door_light, full_light, entry_ack | exit_ack | exit_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0;
    for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (state !== ST_IDLE || occupied !== 4'b0000 || free_count !== 3'd4 || next_slot !== 2'd0 ||
        grant_slot !== 2'd0 || entry_ack !== 1'b0 || exit_ack !== 1'b0 || exit_err !== 1'b0 ||
        door_light !== 1'b0 || full_light !== 1'b0) begin
      errors++; $display("FAIL reset_values: got st=%0d occ=%b free=%0d next=%0d grant=%0d expected 0,0000,4,0,0",
                         state, occupied, free_count, next_slot, grant_slot);
    end
`ifdef PARKING_STATS_EN
    checks++;
    if (total_entries !== 16'd0 || total_exits !== 16'd0 || total_rejects !== 16'd0) begin
      errors++; $display("FAIL reset_stats: got %0d %0d %0d expected 0 0 0", total_entries, total_exits, total_rejects);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int k = 0; k < SLOTS; k++) do_op(1'b1, 0, 1'b0, "fill");
    checks++;
    if (occupied !== 4'b1111 || free_count !== 3'd0) begin
      errors++; $display("FAIL fill_final: got occ=%b free=%0d expected 1111 0", occupied, free_count);
    end
  endtask

  task automatic test_full();
    do_op(1'b1, 0, 1'b0, "full");
    checks++;
    if (occupied !== 4'b1111) begin
      errors++; $display("FAIL full_bitmap: got %b expected 1111", occupied);
    end
  endtask

  task automatic test_exit_valid();
    do_op(1'b0, 2, 1'b0, "exit2");
    checks++;
    if (occupied !== 4'b1011 || free_count !== 3'd1 || next_slot !== 2'd2) begin
      errors++; $display("FAIL exit2_state: got occ=%b free=%0d next=%0d expected 1011 1 2", occupied, free_count, next_slot);
    end
    do_op(1'b1, 0, 1'b0, "refill2");
  endtask

  task automatic test_exit_err();
    apply_reset();
    do_op(1'b1, 0, 1'b0, "one_entry");
    do_op(1'b0, 1, 1'b0, "exit_empty");
    checks++;
    if (occupied !== 4'b0001) begin
      errors++; $display("FAIL exit_empty_bitmap: got %b expected 0001", occupied);
    end
  endtask

  task automatic test_both();
    do_op(1'b1, 0, 1'b1, "both_req");
    checks++;
    if (occupied !== 4'b0011) begin
      errors++; $display("FAIL both_bitmap: got %b expected 0011", occupied);
    end
  endtask

  task automatic test_reset_mid_door();
    entry_req = 1'b1;
    @(negedge clk);
    entry_req = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++;
    if (state !== ST_DOOR) begin
      errors++; $display("FAIL mid_door_state: got %0d expected %0d", state, ST_DOOR);
    end
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
    checks++;
    if (state !== ST_IDLE || occupied !== 4'b0000 || free_count !== 3'd4 || door_light !== 1'b0) begin
      errors++; $display("FAIL async_reset: got st=%0d occ=%b free=%0d dl=%b expected 0 0000 4 0",
                         state, occupied, free_count, door_light);
    end
`ifdef PARKING_STATS_EN
    checks++;
    if (total_entries !== 16'd0 || total_exits !== 16'd0 || total_rejects !== 16'd0) begin
      errors++; $display("FAIL async_reset_stats: got %0d %0d %0d expected 0 0 0", total_entries, total_exits, total_rejects);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || door_light !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got st=%0d dl=%b expected 0 0", state, door_light);
    end
  endtask

  task automatic test_random();
    bit is_entry;
    for (int k = 0; k < 40; k++) begin
      is_entry = ($urandom_range(0, 99) < 55);
      do_op(is_entry, int'($urandom_range(0, SLOTS - 1)), is_entry && ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_exit_valid();
    test_exit_err();
    test_both();
    test_reset_mid_door();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
